// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a synchronous single-port SRAM; one transaction in flight.
// Optional per-beat address range check: define AXI_SRAM_RANGE_CHK_EN.
module axi_sram_responder #(
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  state_e          state_q, state_d;
  logic            rr_wr_q, rr_wr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            fixed_q, fixed_d;
  logic [8:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic            roor_q, roor_d;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [MEM_WORDS];

  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic [31:0]     step;
  logic            mem_we, mem_re;

  assign off  = addr_q - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign step = fixed_q ? '0 : (32'd1 << size_q);

`ifdef AXI_SRAM_RANGE_CHK_EN
  logic unused_off;
  assign in_range   = (off >> (AW + 2)) == 32'd0;
  assign unused_off = ^off[1:0];
`else
  logic unused_off;
  assign in_range   = 1'b1;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  always_comb begin
    state_d  = state_q;
    rr_wr_d  = rr_wr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    size_d   = size_q;
    fixed_d  = fixed_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    roor_d   = roor_q;
    awready  = 1'b0;
    arready  = 1'b0;
    wready   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arvalid && (!awvalid || !rr_wr_q)) begin
          arready = 1'b1;
          rr_wr_d = !rr_wr_q;
          id_d    = arid;
          addr_d  = araddr;
          size_d  = (arsize > 3'd2) ? 2'd2 : arsize[1:0];
          fixed_d = (arburst == 2'b00);
          cnt_d   = {1'b0, arlen} + 9'd1;
          state_d = RD_DATA;
        end else if (awvalid) begin
          awready = 1'b1;
          rr_wr_d = !rr_wr_q;
          id_d    = awid;
          addr_d  = awaddr;
          size_d  = (awsize > 3'd2) ? 2'd2 : awsize[1:0];
          fixed_d = (awburst == 2'b00);
          cnt_d   = {1'b0, awlen} + 9'd1;
          err_d   = 1'b0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we = in_range;
          cnt_d  = cnt_q - 9'd1;
          addr_d = addr_q + step;
          // the beat count, not wlast, closes the burst
          if (!in_range || (wlast != (cnt_q == 9'd1))) err_d = 1'b1;
          if (cnt_q == 9'd1) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) state_d = IDLE;
      end
      RD_DATA: begin
        // one-entry pipeline: fetch whenever the output slot is empty or draining
        if ((cnt_q != 9'd0) && (!rvalid_q || rready)) begin
          mem_re   = 1'b1;
          cnt_d    = cnt_q - 9'd1;
          addr_d   = addr_q + step;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == 9'd1);
          roor_d   = !in_range;
        end else if (rvalid_q && rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_wr_q  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      fixed_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      roor_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_wr_q  <= rr_wr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      fixed_q  <= fixed_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      roor_q   <= roor_d;
    end
  end

  // SRAM array and its read register are never reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (mem_re) rdata_q <= mem[idx];
  end

  assign bvalid = (state_q == WR_RESP);
  assign bid    = id_q;
  assign bresp  = (bvalid && err_q) ? 2'b10 : 2'b00;
  assign rvalid = rvalid_q;
  assign rid    = id_q;
  assign rlast  = rvalid_q & rlast_q;
  assign rresp  = (rvalid_q && roor_q) ? 2'b10 : 2'b00;
  assign rdata  = (rvalid_q && !roor_q) ? rdata_q : '0;

endmodule
